// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus memory-mapped RX/TX FIFOs behind a
// registered single-cycle read port for the pipelined core.
module dmem_responder #(
  parameter int          DEPTH      = 4096,
  parameter logic [31:0] IO_BASE    = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  input  logic        rden,
  output logic [31:0] q_dmem,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int RAW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [31:0] ramMem [DEPTH];
  logic [31:0] rxMem  [FIFO_DEPTH];
  logic [31:0] txMem  [FIFO_DEPTH];

  logic [AW-1:0] rxWr_q, rxWr_d, rxRd_q, rxRd_d;
  logic [AW-1:0] txWr_q, txWr_d, txRd_q, txRd_d;
  logic [CW-1:0] rxCnt_q, rxCnt_d, txCnt_q, txCnt_d;
  logic          rxUnder_q, rxUnder_d, txOver_q, txOver_d;
  logic          live_q;
  logic [31:0]   q_d;

  logic isRam, selRx, selStatus, selTx, selCtrl;
  logic rxEmpty, rxFull, txEmpty, txFull;
  logic rxPush, rxRead, rxPop, underSet;
  logic txWrite, txPush, overSet, txPop;
  logic ctrlWr, flush;
  logic [RAW-1:0] ramIdx;
  logic [31:0] status;

  assign isRam     = address_dmem < 32'(DEPTH);
  assign ramIdx    = address_dmem[RAW-1:0];
  assign selRx     = address_dmem == IO_BASE;
  assign selStatus = address_dmem == IO_BASE + 32'd1;
  assign selTx     = address_dmem == IO_BASE + 32'd2;
  assign selCtrl   = address_dmem == IO_BASE + 32'd3;

  assign rxEmpty = rxCnt_q == '0;
  assign rxFull  = rxCnt_q == FULL_CNT;
  assign txEmpty = txCnt_q == '0;
  assign txFull  = txCnt_q == FULL_CNT;

  // in_ready stays low until the first edge after reset release
  assign in_ready  = live_q & ~rxFull;
  assign out_valid = ~txEmpty;
  assign out_data  = out_valid ? txMem[txRd_q] : '0;

  assign rxPush   = in_valid & in_ready;
  assign rxRead   = selRx & ~wren;
  assign rxPop    = rxRead & rden & ~rxEmpty;
  assign underSet = rxRead & rxEmpty;
  assign txWrite  = selTx & wren;
  assign txPush   = txWrite & ~txFull;
  assign overSet  = txWrite & txFull;
  assign txPop    = out_valid & out_ready;
  assign ctrlWr   = selCtrl & wren;
  assign flush    = ctrlWr & data[2];

  assign status = {8'd0, 8'(txCnt_q), 8'(rxCnt_q), 2'b00,
                   txOver_q, rxUnder_q, txFull, ~txEmpty, rxFull, ~rxEmpty};

  always_comb begin
    q_d = '0;
    if (isRam)
      q_d = ramMem[ramIdx];
    else if (selRx && !rxEmpty)
      q_d = rxMem[rxRd_q];
    else if (selStatus)
      q_d = status;
  end

  always_comb begin
    rxWr_d    = rxWr_q;
    rxRd_d    = rxRd_q;
    txWr_d    = txWr_q;
    txRd_d    = txRd_q;
    rxCnt_d   = rxCnt_q + CW'(rxPush) - CW'(rxPop);
    txCnt_d   = txCnt_q + CW'(txPush) - CW'(txPop);
    rxUnder_d = (rxUnder_q | underSet) & ~(ctrlWr & data[0]);
    txOver_d  = (txOver_q | overSet) & ~(ctrlWr & data[1]);
    if (rxPush) rxWr_d = rxWr_q + AW'(1);
    if (rxPop)  rxRd_d = rxRd_q + AW'(1);
    if (txPush) txWr_d = txWr_q + AW'(1);
    if (txPop)  txRd_d = txRd_q + AW'(1);
    // a flush overrides any same-cycle push or pop
    if (flush) begin
      rxWr_d  = '0;
      rxRd_d  = '0;
      txWr_d  = '0;
      txRd_d  = '0;
      rxCnt_d = '0;
      txCnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (wren && isRam) ramMem[ramIdx] <= data;
    if (rxPush)        rxMem[rxWr_q]  <= in_data;
    if (txPush)        txMem[txWr_q]  <= data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_dmem    <= '0;
      rxWr_q    <= '0;
      rxRd_q    <= '0;
      txWr_q    <= '0;
      txRd_q    <= '0;
      rxCnt_q   <= '0;
      txCnt_q   <= '0;
      rxUnder_q <= 1'b0;
      txOver_q  <= 1'b0;
      live_q    <= 1'b0;
    end else begin
      q_dmem    <= q_d;
      rxWr_q    <= rxWr_d;
      rxRd_q    <= rxRd_d;
      txWr_q    <= txWr_d;
      txRd_q    <= txRd_d;
      rxCnt_q   <= rxCnt_d;
      txCnt_q   <= txCnt_d;
      rxUnder_q <= rxUnder_d;
      txOver_q  <= txOver_d;
      live_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: queue-based reference model with a per-cycle
// compare process, directed scenarios with literal values, then random traffic.
module tb_dmem_responder;

  localparam int          DEPTH   = 4096;
  localparam logic [31:0] IO_BASE = 32'h0000_1000;
  localparam int          FD      = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0, wdata = '0, inData = '0;
  logic        wren = 1'b0, rden = 1'b0, inValid = 1'b0, outReady = 1'b0;
  logic [31:0] q_dmem, out_data;
  logic        in_ready, out_valid;

  dmem_responder #(.DEPTH(DEPTH), .IO_BASE(IO_BASE), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset), .address_dmem(addr), .data(wdata),
    .wren(wren), .rden(rden), .q_dmem(q_dmem), .in_data(inData),
    .in_valid(inValid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(outReady)
  );

  always #5 clock = ~clock;

  logic [31:0] rxQ[$];
  logic [31:0] txQ[$];
  logic [31:0] ramM[int];
  bit          underM, overM, modelLive, expQKnown, checkEn;
  logic [31:0] expQ;
  int          nChecks = 0, nFails = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] modelStatus();
    int s = 0;
    if (rxQ.size() > 0)  s += 1;
    if (rxQ.size() == FD) s += 2;
    if (txQ.size() > 0)  s += 4;
    if (txQ.size() == FD) s += 8;
    if (underM) s += 16;
    if (overM)  s += 32;
    s += rxQ.size() * 256 + txQ.size() * 65536;
    return 32'(s);
  endfunction

  task automatic modelReset();
    rxQ.delete();
    txQ.delete();
    underM = 0; overM = 0; modelLive = 0;
    expQ = '0; expQKnown = 1;
  endtask

  // One clock of traffic: predict from pre-edge model state, then commit after the edge.
  task automatic applyStimulus();
    logic [31:0] rd, a, wd, ind;
    bit known, we, re, iv, orr;
    bit rdRx, popRx, underSet, pushRx, txWr, pushTx, overSet, popTx, ctrl;
    a = addr; wd = wdata; ind = inData; we = wren; re = rden; iv = inValid; orr = outReady;
    rd = '0; known = 1;
    if (a < DEPTH) begin
      if (ramM.exists(int'(a))) rd = ramM[int'(a)];
      else known = 0;
    end else if (a == IO_BASE) rd = (rxQ.size() > 0) ? rxQ[0] : '0;
    else if (a == IO_BASE + 1) rd = modelStatus();
    rdRx     = !we && a == IO_BASE;
    popRx    = rdRx && re && rxQ.size() > 0;
    underSet = rdRx && rxQ.size() == 0;
    pushRx   = iv && modelLive && rxQ.size() < FD;
    txWr     = we && a == IO_BASE + 2;
    pushTx   = txWr && txQ.size() < FD;
    overSet  = txWr && !pushTx;
    popTx    = orr && txQ.size() > 0;
    ctrl     = we && a == IO_BASE + 3;
    @(posedge clock);
    if (popRx)  void'(rxQ.pop_front());
    if (pushRx) rxQ.push_back(ind);
    if (popTx)  void'(txQ.pop_front());
    if (pushTx) txQ.push_back(wd);
    underM = (underM || underSet) && !(ctrl && wd[0]);
    overM  = (overM || overSet) && !(ctrl && wd[1]);
    if (ctrl && wd[2]) begin rxQ.delete(); txQ.delete(); end
    if (we && a < DEPTH) ramM[int'(a)] = wd;
    modelLive = 1;
    expQ = rd; expQKnown = known;
    #1;
  endtask

  // Compare process: every negedge while out of reset.
  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("in_ready", 32'(in_ready), 32'(modelLive && rxQ.size() < FD));
      checkOutput("out_valid", 32'(out_valid), 32'(txQ.size() > 0));
      if (txQ.size() > 0) checkOutput("out_data", out_data, txQ[0]);
      if (expQKnown) checkOutput("q_dmem", q_dmem, expQ);
    end
  end

  task automatic checkLit(input string name, input logic [31:0] lit);
    checkOutput(name, q_dmem, lit);
    checkOutput({"model_", name}, expQ, lit);
  endtask

  task automatic setIdle();
    addr = IO_BASE + 8; wren = 0; rden = 0; wdata = '0; inValid = 0;
  endtask

  task automatic access(input logic [31:0] a, input bit we, input bit re, input logic [31:0] d);
    addr = a; wren = we; rden = re; wdata = d;
    applyStimulus();
  endtask

  task automatic pushRx(input logic [31:0] d);
    setIdle(); inValid = 1; inData = d;
    applyStimulus();
    inValid = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    modelReset();
    checkEn = 0;
    #1;
    checkOutput("rst_q", q_dmem, 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    #11 reset = 1;
    setIdle();
    applyStimulus();
    checkEn = 1;
    checkOutput("ready_after_release", 32'(in_ready), 32'h1);

    // RAM write then read, and read-before-write
    access(5, 1, 0, 32'hDEADBEEF);
    access(5, 0, 1, 32'h0);
    checkLit("ram_rd", 32'hDEADBEEF);
    access(5, 1, 0, 32'h12345678);
    checkLit("ram_rbw", 32'hDEADBEEF);
    access(5, 0, 0, 32'h0);
    checkLit("ram_new", 32'h12345678);

    // RX ordering, underflow, clear
    for (int i = 1; i <= 3; i++) pushRx(32'(i));
    for (int i = 1; i <= 3; i++) begin
      access(IO_BASE, 0, 1, 0);
      checkLit("rx_pop", 32'(i));
    end
    access(IO_BASE, 0, 1, 0);
    checkLit("rx_empty_pop", 32'h0);
    access(IO_BASE + 1, 0, 0, 0);
    checkLit("status_under", 32'h0000_0010);
    access(IO_BASE + 3, 1, 0, 32'h1);
    access(IO_BASE + 1, 0, 0, 0);
    checkLit("status_cleared", 32'h0);

    // RX full and pointer wrap
    for (int i = 0; i < 8; i++) pushRx(32'h10 + 32'(i));
    checkOutput("rx_full_ready", 32'(in_ready), 32'h0);
    access(IO_BASE + 1, 0, 0, 0);
    checkLit("status_rx_full", 32'h0000_0803);
    for (int i = 0; i < 3; i++) begin
      access(IO_BASE, 0, 1, 0);
      checkLit("rx_wrap_pop", 32'h10 + 32'(i));
    end
    for (int i = 0; i < 3; i++) pushRx(32'h20 + 32'(i));
    access(IO_BASE + 1, 0, 0, 0);
    checkLit("status_rx_wrap", 32'h0000_0803);
    for (int i = 0; i < 8; i++) begin
      access(IO_BASE, 0, 1, 0);
      checkLit("rx_wrap_order", (i < 5) ? 32'h13 + 32'(i) : 32'h20 + 32'(i - 5));
    end

    // TX fill, overflow, drain
    access(IO_BASE + 2, 1, 0, 32'hA);
    access(IO_BASE + 2, 1, 0, 32'hB);
    checkOutput("tx_valid", 32'(out_valid), 32'h1);
    checkOutput("tx_head", out_data, 32'hA);
    for (int i = 0; i < 7; i++) access(IO_BASE + 2, 1, 0, 32'hC + 32'(i));
    access(IO_BASE + 1, 0, 0, 0);
    checkLit("status_tx_over", 32'h0008_002C);
    setIdle(); outReady = 1;
    for (int i = 0; i < 8; i++) begin
      checkOutput("tx_order", out_data, 32'hA + 32'(i));
      applyStimulus();
    end
    outReady = 0;
    checkOutput("tx_drained", 32'(out_valid), 32'h0);
    access(IO_BASE + 3, 1, 0, 32'h2);

    // Simultaneous push/pop, then flush with a same-cycle push
    for (int i = 0; i < 4; i++) pushRx(32'h30 + 32'(i));
    inValid = 1; inData = 32'h34;
    access(IO_BASE, 0, 1, 0);
    checkLit("rx_pushpop", 32'h30);
    inValid = 0;
    access(IO_BASE + 1, 0, 0, 0);
    checkLit("status_count4", 32'h0000_0401);
    access(IO_BASE + 2, 1, 0, 32'h55);
    inValid = 1; inData = 32'h99;
    access(IO_BASE + 3, 1, 0, 32'h4);
    inValid = 0;
    access(IO_BASE + 1, 0, 0, 0);
    checkLit("status_flushed", 32'h0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      int sel;
      sel = $urandom_range(0, 6);
      rden = 1'($urandom_range(0, 1));
      wdata = $urandom;
      case (sel)
        0, 1: begin addr = 32'($urandom_range(0, 15)); wren = 1'($urandom_range(0, 1)); end
        2:    begin addr = IO_BASE;     wren = 0; end
        3:    begin addr = IO_BASE + 1; wren = 0; end
        4:    begin addr = IO_BASE + 2; wren = 1; end
        5:    begin
                addr = IO_BASE + 3; wren = 1;
                wdata = {29'd0, ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3))};
              end
        default: begin
                addr = ($urandom_range(0, 1) == 1) ? IO_BASE + 4 + 32'($urandom_range(0, 3))
                                                   : 32'(DEPTH) + 32'($urandom_range(0, 7));
                wren = 1'($urandom_range(0, 1));
              end
      endcase
      inValid = 1'($urandom_range(0, 1));
      inData = $urandom;
      outReady = ($urandom_range(0, 2) != 0);
      applyStimulus();
    end

    // Reset mid-stream with both FIFOs occupied and a handshake in flight
    setIdle(); outReady = 0;
    access(IO_BASE + 3, 1, 0, 32'h7);
    for (int i = 0; i < 3; i++) pushRx(32'h40 + 32'(i));
    access(IO_BASE + 2, 1, 0, 32'h77);
    access(IO_BASE + 2, 1, 0, 32'h78);
    access(IO_BASE, 0, 0, 0);
    inValid = 1; inData = 32'h50;
    checkEn = 0;
    #2 reset = 0;
    #1;
    checkOutput("midrst_q", q_dmem, 32'h0);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'h0);
    checkOutput("midrst_out_data", out_data, 32'h0);
    modelReset();
    @(posedge clock);
    #3 reset = 1;
    setIdle();
    applyStimulus();
    checkEn = 1;
    access(IO_BASE + 1, 0, 0, 0);
    checkLit("status_after_reset", 32'h0);
    setIdle();
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined processor's dmem port. It answers `address_dmem`/`data`/`wren` with a registered `q_dmem` from an internal word RAM. It also memory-maps two FIFOs (RX from external producer, TX to external consumer), which move ciphertext and plaintext between the core and the outside world. It sits in Wrapper beside the regfile and replaces the bare dmem instance.

## Interface
Parameters:
- `DEPTH`, 4096: RAM words, word-addressed 0..DEPTH-1.
- `IO_BASE`, 32'h0000_1000: base word address of the I/O registers; must be ≥ DEPTH.
- `FIFO_DEPTH`, 8: entries per FIFO, power of two, ≤128.

Ports:
- `clock` in 1: master clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `address_dmem` in 32: word address from the core.
- `data` in 32: write data from the core.
- `wren` in 1: write strobe, one access per asserted cycle.
- `rden` in 1: load strobe; the core asserts it for exactly one cycle per load instruction.
- `q_dmem` out 32: registered read data.
- `in_data` in 32: RX word from the external producer.
- `in_valid` in 1: RX word offered.
- `in_ready` out 1: RX FIFO can accept.
- `out_data` out 32: TX FIFO head.
- `out_valid` out 1: TX FIFO non-empty.
- `out_ready` in 1: external consumer takes the head.

## Operation
Address decode on `address_dmem`:
- RAM: 0..DEPTH-1.
- `IO_BASE`+0, RX_DATA, read-only.
- `IO_BASE`+1, STATUS, read-only.
- `IO_BASE`+2, TX_DATA, write-only.
- `IO_BASE`+3, CTRL, write-only.
- Any other address: reads return 0, writes are dropped.

RAM:
- Single port, read-before-write.
- A cycle with `wren`=1 returns the old word on `q_dmem`.

RX_DATA:
- A read with `rden`=1 returns the FIFO head and pops it.
- Read with `rden`=0 returns the head without popping.
- Read while empty: returns 0 and sets sticky `rx_underflow`.

STATUS:
- [0] rx non-empty.
- [1] rx full.
- [2] tx non-empty.
- [3] tx full.
- [4] `rx_underflow`.
- [5] `tx_overflow`.
- [15:8] rx count.
- [23:16] tx count.
- All other bits 0.

TX_DATA write: pushes `data`. Write while full: word dropped, sticky `tx_overflow` set.

CTRL write, bits take effect simultaneously:
- `data[0]` clears `rx_underflow`.
- `data[1]` clears `tx_overflow`.
- `data[2]` flushes both FIFOs (pointers and counts to 0).

External handshakes:
- RX push occurs when `in_valid & in_ready`.
- TX pop occurs when `out_valid & out_ready`.
- `in_ready` = ~rx_full; `out_valid` = tx non-empty; `out_data` = TX head, meaningful only when `out_valid`.

FIFO storage:
- Circular buffer, log2(FIFO_DEPTH)-bit pointers wrapping modulo FIFO_DEPTH.
- Count width log2(FIFO_DEPTH)+1.

Simultaneous events:
- Push and pop on the same FIFO in one cycle: both happen, count unchanged. A pop on a full FIFO plus a push is impossible, since `in_ready`=0.
- Pop from empty with a simultaneous push: returns 0, underflow set, pushed word retained (no bypass).
- Flush with a same-cycle push or pop: flush wins, FIFO ends empty; sticky flags are updated per the access.
- Sticky set and CTRL clear in the same cycle: clear wins.
- `wren` and `rden` both high: write performed, `rden` ignored.

## Timing
- Access latency 1 cycle: `address_dmem`/`wren`/`rden` sampled at edge k; `q_dmem` updates after edge k and holds until edge k+1.
- STATUS reflects state before edge k, so it excludes same-edge pushes and pops.
- FIFO state, sticky flags and RAM writes update at edge k.
- `in_ready`, `out_valid` and `out_data` derive from registered state only and have no combinational path from `in_valid`/`out_ready`.
- Reset (`reset`=0, async) clears, independent of clock:
  - `q_dmem` = 0.
  - Both FIFOs empty, both stickies 0.
  - `out_valid` = 0, `out_data` = 0.
  - `in_ready` = 0 while `reset` is low; `in_ready` = 1 from the first edge after release.
- RAM contents are not reset.
- A reset asserted mid-stream discards all FIFO contents; an in-flight external handshake is not completed.

## Test plan
- RAM: write 0xDEADBEEF to address 5 at edge k; read address 5 at edge k+1 -> `q_dmem`=0xDEADBEEF after k+1. A write/read of address 5 in the same cycle returns the prior value.
- RX: push 1, 2, 3 via `in_valid`; three RX_DATA reads with `rden` -> 1, 2, 3. A fourth read -> 0 and STATUS[4]=1. CTRL write of 1 -> STATUS[4]=0.
- Full and wrap: push 8 words with FIFO_DEPTH=8 -> `in_ready`=0, STATUS[1]=1, STATUS[15:8]=8. Pop 3 and push 3 -> ordering preserved across wrap, count stays 8.
- TX: write 0xA, 0xB to TX_DATA with `out_ready`=0 -> `out_valid`=1, `out_data`=0xA. Write 7 more -> STATUS[5]=1, count 8. Raise `out_ready` -> 0xA, 0xB, … in order.
- Simultaneous: RX push and RX_DATA pop on one edge at count 4 -> count stays 4. CTRL flush with a same-cycle `in_valid` -> both counts 0.
- Reset: drop `reset` mid-transfer with FIFOs non-empty -> `q_dmem`=0, `out_valid`=0, `in_ready`=0 immediately. After release, STATUS reads 0.
